// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, pattern encodings and colour values.
// Used by the timing generator and by the pattern generator downstream of it.
package vga_pkg;

  localparam int H_Visible_area = 640;
  localparam int H_Front_porch  = 16;
  localparam int H_Sync_pulse   = 96;
  localparam int H_Back_porch   = 48;
  localparam int H_Whole_line   = 800;

  localparam int V_Visible_area = 480;
  localparam int V_Front_porch  = 10;
  localparam int V_Sync_pulse   = 2;
  localparam int V_Back_porch   = 33;
  localparam int V_Whole_frame  = 525;

  // First visible counts: sync pulse plus back porch.
  localparam int H2 = H_Sync_pulse + H_Back_porch;
  localparam int V2 = V_Sync_pulse + V_Back_porch;

  localparam int BOX_SIZE    = 32;
  localparam int BOX_STEP    = 4;
  localparam int CHECK_SHIFT = 5;
  localparam int BAR_W       = H_Visible_area / 8;

  typedef enum logic [1:0] {
    BARS   = 2'd0,
    CHECK  = 2'd1,
    BOX    = 2'd2,
    BORDER = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    dir_e       dir;
    logic [9:0] pos;
  } axis_t;

  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_YELLOW  = 12'hFF0;
  localparam logic [11:0] COL_CYAN    = 12'h0FF;
  localparam logic [11:0] COL_GREEN   = 12'h0F0;
  localparam logic [11:0] COL_MAGENTA = 12'hF0F;
  localparam logic [11:0] COL_RED     = 12'hF00;
  localparam logic [11:0] COL_BLUE    = 12'h00F;
  localparam logic [11:0] COL_BLACK   = 12'h000;
  localparam logic [11:0] COL_BOX_BG  = 12'h008;

  // Eight equal bars selected by a compare ladder on x, avoiding a divider.
  function automatic logic [11:0] bar_colour(input logic [9:0] x);
    logic [11:0] c;
    if      (x < 10'(BAR_W * 1)) c = COL_WHITE;
    else if (x < 10'(BAR_W * 2)) c = COL_YELLOW;
    else if (x < 10'(BAR_W * 3)) c = COL_CYAN;
    else if (x < 10'(BAR_W * 4)) c = COL_GREEN;
    else if (x < 10'(BAR_W * 5)) c = COL_MAGENTA;
    else if (x < 10'(BAR_W * 6)) c = COL_RED;
    else if (x < 10'(BAR_W * 7)) c = COL_BLUE;
    else                         c = COL_BLACK;
    return c;
  endfunction

  // One bounce step along an axis; 11-bit sums keep the bound compare exact.
  function automatic axis_t axis_step(input logic [9:0] pos, input dir_e dir,
                                      input logic [10:0] visible);
    axis_t nxt;
    nxt.pos = pos;
    nxt.dir = dir;
    if (dir == DIR_POS) begin
      if ({1'b0, pos} + 11'(BOX_SIZE) + 11'(BOX_STEP) > visible) begin
        nxt.pos = 10'(visible - 11'(BOX_SIZE));
        nxt.dir = DIR_NEG;
      end else begin
        nxt.pos = pos + 10'(BOX_STEP);
      end
    end else begin
      if (pos < 10'(BOX_STEP)) begin
        nxt.pos = '0;
        nxt.dir = DIR_POS;
      end else begin
        nxt.pos = pos - 10'(BOX_STEP);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: steps both axes once per frame tick and reverses
// direction at the visible-area edges.
module vga_box_mover
  import vga_pkg::*;
(
  input  logic       CLK_25M,
  input  logic       FPGA_RST,
  input  logic       step_en,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  logic [9:0] box_x_q;
  logic [9:0] box_y_q;
  dir_e       dir_x_q;
  dir_e       dir_y_q;
  axis_t      nxt_x;
  axis_t      nxt_y;

  always_comb begin
    nxt_x = axis_step(box_x_q, dir_x_q, 11'(H_Visible_area));
    nxt_y = axis_step(box_y_q, dir_y_q, 11'(V_Visible_area));
  end

  always_ff @(posedge CLK_25M) begin
    if (FPGA_RST) begin
      box_x_q <= '0;
      box_y_q <= '0;
      dir_x_q <= DIR_POS;
      dir_y_q <= DIR_POS;
    end else if (step_en) begin
      box_x_q <= nxt_x.pos;
      box_y_q <= nxt_y.pos;
      dir_x_q <= nxt_x.dir;
      dir_y_q <= nxt_y.dir;
    end
  end

  assign box_x = box_x_q;
  assign box_y = box_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Pixel stage behind the VGA timing generator: two-stage pipeline producing
// 4-bit RGB test patterns with syncs delayed to stay aligned with the pixels.
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic       CLK_25M,
  input  logic       FPGA_RST,
  input  logic [9:0] HS_Count,
  input  logic [9:0] VS_Count,
  input  logic       Data_valid,
  input  logic       VGA_HS_in,
  input  logic       VGA_VS_in,
  input  logic [1:0] Mode,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       Frame_tick
);

  localparam logic [9:0] H_LAST = 10'(H_Whole_line - 1);
  localparam logic [9:0] V_LAST = 10'(V_Whole_frame - 1);
  localparam logic [9:0] X_LAST = 10'(H_Visible_area - 1);
  localparam logic [9:0] Y_LAST = 10'(V_Visible_area - 1);

  logic        frame_end;
  logic [9:0]  s1_x;
  logic [9:0]  s1_y;
  logic        s1_valid;
  logic        s1_hs;
  logic        s1_vs;
  logic [11:0] rgb_q;
  logic        hs_q;
  logic        vs_q;
  logic        tick_q;
  mode_e       mode_q;
  logic [9:0]  box_x;
  logic [9:0]  box_y;
  logic        in_box;
  logic        on_border;
  logic [11:0] pix;

  assign frame_end = (HS_Count == H_LAST) && (VS_Count == V_LAST);

  // The box only moves on the frame tick, which falls in blanking, so stage 2
  // sees one position for the whole visible frame.
  vga_box_mover u_box (
    .CLK_25M  (CLK_25M),
    .FPGA_RST (FPGA_RST),
    .step_en  (frame_end),
    .box_x    (box_x),
    .box_y    (box_y)
  );

  always_comb begin
    in_box = ({1'b0, s1_x} >= {1'b0, box_x}) &&
             ({1'b0, s1_x} <  {1'b0, box_x} + 11'(BOX_SIZE)) &&
             ({1'b0, s1_y} >= {1'b0, box_y}) &&
             ({1'b0, s1_y} <  {1'b0, box_y} + 11'(BOX_SIZE));
    on_border = (s1_x == '0) || (s1_x == X_LAST) ||
                (s1_y == '0) || (s1_y == Y_LAST);
  end

  always_comb begin
    pix = COL_BLACK;
    case (mode_q)
      BARS:    pix = bar_colour(s1_x);
      CHECK:   pix = (s1_x[CHECK_SHIFT] ^ s1_y[CHECK_SHIFT]) ? COL_WHITE : COL_BLACK;
      BOX:     pix = in_box ? COL_RED : COL_BOX_BG;
      BORDER:  pix = on_border ? COL_WHITE : COL_BLACK;
      default: pix = COL_BLACK;
    endcase
    if (!s1_valid) pix = COL_BLACK;
  end

  always_ff @(posedge CLK_25M) begin
    if (FPGA_RST) begin
      s1_x     <= '0;
      s1_y     <= '0;
      s1_valid <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      rgb_q    <= '0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      tick_q   <= 1'b0;
      mode_q   <= BARS;
    end else begin
      s1_x     <= HS_Count - 10'(H2);
      s1_y     <= VS_Count - 10'(V2);
      s1_valid <= Data_valid;
      s1_hs    <= VGA_HS_in;
      s1_vs    <= VGA_VS_in;
      rgb_q    <= pix;
      hs_q     <= s1_hs;
      vs_q     <= s1_vs;
      tick_q   <= frame_end;
      // Mode takes effect only at the frame boundary to avoid tearing.
      if (frame_end) mode_q <= mode_e'(Mode);
    end
  end

  assign VGA_R      = rgb_q[11:8];
  assign VGA_G      = rgb_q[7:4];
  assign VGA_B      = rgb_q[3:0];
  assign VGA_HS     = hs_q;
  assign VGA_VS     = vs_q;
  assign Frame_tick = tick_q;

endmodule
